// File: rtl/stereo_pkg.sv
// Shared width constants and state type for the 48-bit SSD row path.
// The MAC engine imports the same constants so both sides agree on row geometry.
package stereo_pkg;

    localparam int PIXEL_W = 8;
    localparam int LANES   = 6;
    localparam int ROW_W   = 48;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

    // Place one pixel into lane 'lane' of a row; lane 0 is the MSB byte.
    // Out-of-range lanes leave the row untouched.
    function automatic logic [ROW_W-1:0] lane_insert(
        input logic [ROW_W-1:0]   row,
        input logic [PIXEL_W-1:0] pix,
        input logic [2:0]         lane
    );
        logic [ROW_W-1:0] res;
        res = row;
        for (int k = 0; k < LANES; k++) begin
            if (lane == 3'(k)) begin
                res[ROW_W-1-PIXEL_W*k -: PIXEL_W] = pix;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stereo_row_packer.sv
// Packs six left/right pixel pairs into 48-bit rows for the SSD MAC engine.
// A pack register fills while an output register presents; when the output
// is stalled a completed row waits in the pack register and input is paused.
module stereo_row_packer
    import stereo_pkg::*;
#(
    parameter int ROWS_PER_WINDOW = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [PIXEL_W-1:0]  left_pixel_in,
    input  logic [PIXEL_W-1:0]  right_pixel_in,
    input  logic                pixel_valid_in,
    input  logic                pixel_last_in,
    output logic                pixel_ready_out,
    output logic [ROW_W-1:0]    left_row,
    output logic [ROW_W-1:0]    right_row,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                window_last_out
);

    localparam int                CNT_W     = (ROWS_PER_WINDOW > 1) ? $clog2(ROWS_PER_WINDOW) : 1;
    localparam logic [CNT_W-1:0]  ROW_LAST  = CNT_W'(ROWS_PER_WINDOW - 1);
    localparam logic [2:0]        LANE_LAST = 3'(LANES - 1);

    packer_state_t      r_state;
    packer_state_t      w_state_nxt;
    logic [2:0]         r_lane;
    logic [CNT_W-1:0]   r_row_cnt;
    logic               r_ready_en;
    logic [ROW_W-1:0]   r_pack_l;
    logic [ROW_W-1:0]   r_pack_r;
    logic [ROW_W-1:0]   r_out_l;
    logic [ROW_W-1:0]   r_out_r;
    logic               r_valid;
    logic               r_wlast;

    logic               w_accept;
    logic               w_complete;
    logic               w_out_free;
    logic               w_load_direct;
    logic               w_load_pack;
    logic               w_pack_we;
    logic [ROW_W-1:0]   w_base_l;
    logic [ROW_W-1:0]   w_base_r;
    logic [ROW_W-1:0]   w_fill_l;
    logic [ROW_W-1:0]   w_fill_r;

    // Ready is held low through reset and until the first edge after release.
    assign pixel_ready_out = r_ready_en && (r_state == FILL);
    assign w_accept        = pixel_valid_in && pixel_ready_out;
    assign w_complete      = w_accept && ((r_lane == LANE_LAST) || pixel_last_in);
    assign w_out_free      = !r_valid || ready_in;

    // Starting a new group from a cleared base gives zero padding for short lines.
    assign w_base_l = (r_lane == 3'd0) ? {ROW_W{1'b0}} : r_pack_l;
    assign w_base_r = (r_lane == 3'd0) ? {ROW_W{1'b0}} : r_pack_r;
    assign w_fill_l = lane_insert(w_base_l, left_pixel_in, r_lane);
    assign w_fill_r = lane_insert(w_base_r, right_pixel_in, r_lane);

    assign left_row        = r_out_l;
    assign right_row       = r_out_r;
    assign valid_out       = r_valid;
    assign window_last_out = r_wlast;

    // Next-state and load control: decide where a completed row goes.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_direct = 1'b0;
        w_load_pack   = 1'b0;
        w_pack_we     = 1'b0;
        case (r_state)
            FILL: begin
                if (w_complete) begin
                    if (w_out_free) begin
                        w_load_direct = 1'b1;
                    end else begin
                        w_pack_we   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (w_accept) begin
                    w_pack_we = 1'b1;
                end else begin
                    w_pack_we = 1'b0;
                end
            end
            HOLD: begin
                if (w_out_free) begin
                    w_load_pack = 1'b1;
                    w_state_nxt = FILL;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // State register plus the post-reset ready enable.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= FILL;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;
        end
    end

    // Lane counter: advances per accepted pair, restarts when a group completes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_lane <= 3'd0;
        end else if (w_complete) begin
            r_lane <= 3'd0;
        end else if (w_accept) begin
            r_lane <= r_lane + 3'd1;
        end else begin
            r_lane <= r_lane;
        end
    end

    // Pack register: partial groups, or a finished row waiting for the output.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pack_l <= {ROW_W{1'b0}};
            r_pack_r <= {ROW_W{1'b0}};
        end else if (w_pack_we) begin
            r_pack_l <= w_fill_l;
            r_pack_r <= w_fill_r;
        end else begin
            r_pack_l <= r_pack_l;
            r_pack_r <= r_pack_r;
        end
    end

    // Output register: load replaces (even while draining), otherwise hold until taken.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_out_l   <= {ROW_W{1'b0}};
            r_out_r   <= {ROW_W{1'b0}};
            r_valid   <= 1'b0;
            r_wlast   <= 1'b0;
            r_row_cnt <= {CNT_W{1'b0}};
        end else if (w_load_direct || w_load_pack) begin
            r_out_l   <= w_load_direct ? w_fill_l : r_pack_l;
            r_out_r   <= w_load_direct ? w_fill_r : r_pack_r;
            r_valid   <= 1'b1;
            r_wlast   <= (r_row_cnt == ROW_LAST);
            r_row_cnt <= (r_row_cnt == ROW_LAST) ? {CNT_W{1'b0}} : r_row_cnt + CNT_W'(1);
        end else if (r_valid && ready_in) begin
            r_valid   <= 1'b0;
            r_wlast   <= 1'b0;
        end else begin
            r_valid   <= r_valid;
            r_wlast   <= r_wlast;
        end
    end

endmodule

// File: tb/tb_stereo_row_packer.sv
// Self-checking bench for stereo_row_packer: table-driven groups, hand-written
// backpressure / window / reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_stereo_row_packer;

    localparam int RPW = 6;

    logic        clk;
    logic        rst_n;
    logic [7:0]  left_pixel_in;
    logic [7:0]  right_pixel_in;
    logic        pixel_valid_in;
    logic        pixel_last_in;
    logic        pixel_ready_out;
    logic [47:0] left_row;
    logic [47:0] right_row;
    logic        valid_out;
    logic        ready_in;
    logic        window_last_out;

    stereo_row_packer #(.ROWS_PER_WINDOW(RPW)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .left_pixel_in   (left_pixel_in),
        .right_pixel_in  (right_pixel_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_last_in   (pixel_last_in),
        .pixel_ready_out (pixel_ready_out),
        .left_row        (left_row),
        .right_row       (right_row),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .window_last_out (window_last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] l;
        logic [47:0] r;
        logic        w;
    } row_t;

    typedef struct {
        int          n;
        logic [47:0] li;
        logic [47:0] ri;
        logic [47:0] el;
        logic [47:0] er;
    } vec_t;

    int n_pass;
    int n_total;

    // Reference model state: pixels of the open group, rows completed but not taken.
    logic [7:0] m_pl[$];
    logic [7:0] m_pr[$];
    row_t       m_q[$];
    int         m_rows;
    int         n_acc;
    logic       m_acc;

    // Outputs captured at the most recent step's sampling point.
    logic        s_valid;
    logic        s_w;
    logic [47:0] s_l;
    logic [47:0] s_r;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pl.delete();
        m_pr.delete();
        m_q.delete();
        m_rows = 0;
    endtask

    // One clock: check outputs vs the model on the falling edge, drive inputs,
    // advance the model by what the coming rising edge does.
    task automatic step(input logic v, input logic [7:0] l, input logic [7:0] r,
                        input logic last, input logic rdy);
        row_t nr;
        @(negedge clk);
        s_valid = valid_out;
        s_w     = window_last_out;
        s_l     = left_row;
        s_r     = right_row;
        chk("pixel_ready", 64'(pixel_ready_out), 64'(m_q.size() < 2));
        chk("valid_out",   64'(valid_out),       64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("left_row",   64'(left_row),        64'(m_q[0].l));
            chk("right_row",  64'(right_row),       64'(m_q[0].r));
            chk("window_last", 64'(window_last_out), 64'(m_q[0].w));
        end
        pixel_valid_in = v;
        left_pixel_in  = l;
        right_pixel_in = r;
        pixel_last_in  = last;
        ready_in       = rdy;
        m_acc = v && (m_q.size() < 2);
        if (m_q.size() > 0 && rdy) begin
            void'(m_q.pop_front());
        end
        if (m_acc) begin
            n_acc++;
            m_pl.push_back(l);
            m_pr.push_back(r);
            if (last || m_pl.size() == 6) begin
                nr.l = 48'h0;
                nr.r = 48'h0;
                for (int i = 0; i < m_pl.size(); i++) begin
                    nr.l = nr.l | (48'(m_pl[i]) << (8 * (5 - i)));
                    nr.r = nr.r | (48'(m_pr[i]) << (8 * (5 - i)));
                end
                m_rows++;
                nr.w = ((m_rows % RPW) == 0);
                m_q.push_back(nr);
                m_pl.delete();
                m_pr.delete();
            end
        end
        @(posedge clk);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_left",   64'(left_row),        64'h0);
        chk("rst_right",  64'(right_row),       64'h0);
        chk("rst_valid",  64'(valid_out),       64'h0);
        chk("rst_wlast",  64'(window_last_out), 64'h0);
        chk("rst_ready",  64'(pixel_ready_out), 64'h0);
        model_clear();
        pixel_valid_in = 1'b0;
        pixel_last_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[5];
    int   idx;
    int   budget;
    int   acc0;

    initial begin
        n_pass = 0;
        n_total = 0;
        n_acc = 0;
        rst_n = 1'b0;
        left_pixel_in = 8'h00;
        right_pixel_in = 8'h00;
        pixel_valid_in = 1'b0;
        pixel_last_in = 1'b0;
        ready_in = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Groups: full, short (junk beyond n must be padded), single, full, five.
        vecs[0] = '{6, 48'h010203040506, 48'h102030405060, 48'h010203040506, 48'h102030405060};
        vecs[1] = '{3, 48'hAABBCCDDEEFF, 48'h112233445566, 48'hAABBCC000000, 48'h112233000000};
        vecs[2] = '{1, 48'h7F0102030405, 48'h80FFFFFFFFFF, 48'h7F0000000000, 48'h800000000000};
        vecs[3] = '{6, 48'hFFEEDDCCBBAA, 48'h0000FF00FF00, 48'hFFEEDDCCBBAA, 48'h0000FF00FF00};
        vecs[4] = '{5, 48'h0A0B0C0D0E0F, 48'hF1F2F3F4F5F6, 48'h0A0B0C0D0E00, 48'hF1F2F3F4F500};

        for (int t = 0; t < 5; t++) begin
            logic [47:0] li;
            logic [47:0] ri;
            li = vecs[t].li;
            ri = vecs[t].ri;
            for (int k = 0; k < vecs[t].n; k++) begin
                step(1'b1, li[47-8*k -: 8], ri[47-8*k -: 8],
                     (k == vecs[t].n - 1) && (vecs[t].n < 6), 1'b1);
            end
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk("tbl_valid", 64'(s_valid), 64'h1);
            chk("tbl_left",  64'(s_l),     64'(vecs[t].el));
            chk("tbl_right", 64'(s_r),     64'(vecs[t].er));
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk("tbl_one_cycle", 64'(s_valid), 64'h0);
        end

        // Backpressure: 14 pairs offered with the consumer stalled.
        do_reset();
        idx = 1;
        acc0 = n_acc;
        for (int c = 0; c < 14; c++) begin
            step(1'b1, 8'(idx), 8'(8'h80 + idx), 1'b0, 1'b0);
            if (m_acc) idx++;
        end
        #1;
        chk("bp_accepted", 64'(n_acc - acc0), 64'd12);
        chk("bp_ready_low", 64'(pixel_ready_out), 64'h0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_row1_l", 64'(s_l), 64'h010203040506);
        chk("bp_row1_r", 64'(s_r), 64'h818283848586);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_row2_l", 64'(s_l), 64'h0708090A0B0C);
        chk("bp_row2_r", 64'(s_r), 64'h8788898A8B8C);
        acc0 = n_acc;
        budget = 0;
        while ((n_acc - acc0) < 6 && budget < 50) begin
            step(1'b1, 8'(idx), 8'(8'h80 + idx), 1'b0, 1'b1);
            if (m_acc) idx++;
            budget++;
        end
        chk("bp_resume_budget", 64'(n_acc - acc0), 64'd6);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_row3_l", 64'(s_l), 64'h0D0E0F101112);

        // Window marking over 12 rows.
        do_reset();
        for (int g = 0; g < 12; g++) begin
            for (int k = 0; k < 6; k++) begin
                step(1'b1, 8'(g), 8'(k), 1'b0, 1'b1);
            end
            step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            chk("win_valid", 64'(s_valid), 64'h1);
            chk("win_last",  64'(s_w),     64'((g % 6) == 5));
        end

        // Reset discards a partial group.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 8'h55, 8'h66, 1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 8'(8'h21 + k), 8'(8'h31 + k), 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("rstgrp_left",  64'(s_l), 64'h212223242526);
        chk("rstgrp_right", 64'(s_r), 64'h313233343536);
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        chk("rstgrp_single", 64'(s_valid), 64'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            step(($urandom % 4) != 0, 8'($urandom), 8'($urandom),
                 ($urandom % 8) == 0, ($urandom % 3) != 0);
        end
        do_reset();
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stereo_row_packer.md
# stereo_row_packer

Producer side of the 48-bit SSD row interface. Accepts paired left/right 8-bit pixel streams from the rectified-image readers and packs six consecutive pixel pairs into 48-bit `left_row`/`right_row` words with a valid strobe for the 48-bit MAC engine. Marks the last row of each matching window so the downstream cost logic knows when a window sum is complete. Provides input backpressure and output hold so a stalled consumer never loses or reorders rows.

## Interface
Parameters:
- `ROWS_PER_WINDOW`, default 6: rows per matching window (≥1).

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `left_pixel_in` input 8: left image pixel.
- `right_pixel_in` input 8: right image pixel, same position as the left pixel.
- `pixel_valid_in` input 1: pixel pair present.
- `pixel_last_in` input 1: qualifies the current pair as the last pixel of an image line.
- `pixel_ready_out` output 1: the block can accept a pair this cycle.
- `left_row` output 48: packed left pixels.
- `right_row` output 48: packed right pixels.
- `valid_out` output 1: a row is presented.
- `ready_in` input 1: the consumer takes the row. Tie high for the MAC engine.
- `window_last_out` output 1: the presented row closes a window.

## Operation
- A pair is accepted when `pixel_valid_in && pixel_ready_out` at a rising edge.
- Lane placement: the k-th accepted pixel of a group (k = 0..5) goes to bits [47-8k -: 8]. Pixel 0 is the MSB byte.
- Lane counter: 0..5.
  - It wraps to 0 after lane 5.
  - It also resets to 0 when an accepted pair has `pixel_last_in` high.
- Group completion: the group completes on acceptance of lane 5, or on any accepted pair with `pixel_last_in` high.
  - Short groups are zero-padded in lanes k+1..5 in both rows. Padding yields zero difference, so it adds no cost.
- Storage: a pack register (fill side) and an output register (presented side).
- State machine:
  - FILL: `pixel_ready_out`=1.
    - When the completing pair is accepted and the output register is empty or draining this cycle (`valid_out && ready_in`), the row loads directly into the output register and the state stays FILL.
    - Otherwise the row stays in the pack register and the state goes to HOLD.
  - HOLD: `pixel_ready_out`=0.
    - When the output register is empty or draining, the pack row moves to the output register and the state returns to FILL.
- Output register: `valid_out` holds with stable data until `valid_out && ready_in`.
- Row counter: 0..ROWS_PER_WINDOW-1.
  - Increments on each load into the output register and wraps.
  - `window_last_out` is registered alongside the row. It is high when the loaded row is the ROWS_PER_WINDOW-th row, and it is stable for as long as `valid_out` is high.
- Line ends do not reset the row counter. Window alignment belongs to the upstream sequencer.

## Timing
- Reset (asynchronous assert, any cycle): `left_row`=0, `right_row`=0, `valid_out`=0, `window_last_out`=0, lane counter 0, row counter 0, state FILL.
  - `pixel_ready_out`=1 from the first edge after release.
  - A partial group in progress is discarded.
- Latency: `valid_out` rises on the edge that accepts the completing pair, so it is visible the next cycle.
- With `ready_in` held high: one row per 6 accepted pairs, no bubbles. Pixel throughput is one pair per cycle.
- Simultaneous drain and load in the same cycle: `valid_out` stays high and the new data replaces the old. This gives back-to-back rows.
- Maximum buffered rows: 2 (output + pack). After that `pixel_ready_out`=0.
- `pixel_last_in` is ignored unless the pair is accepted.

## Structure
- Shared package `stereo_pkg`: `PIXEL_W`=8, `LANES`=6, `ROW_W`=48, and a state enum `packer_state_t` {FILL, HOLD}. The MAC engine uses the same width constants.
- Single module; no sub-module warranted. The output register with its drain logic stays inline.

## Test plan
- Reset: hold `rst_in`=0 mid-stream → all outputs 0 immediately; after release `pixel_ready_out`=1 and `valid_out`=0.
- Full group: L=01..06, R=10,20,30,40,50,60, `ready_in`=1 → next cycle `left_row`=0x010203040506 and `right_row`=0x102030405060. `valid_out` is high for exactly one cycle.
- Short line: L=AA,BB,CC with `pixel_last_in` on CC → `left_row`=0xAABBCC000000 and right row padded the same way. The next pixel lands in lane 0.
- Backpressure: `ready_in`=0 with 14 pairs offered back to back → two rows buffered and `pixel_ready_out` low after the 12th acceptance. Raising `ready_in` releases both rows in order, then acceptance resumes with no pair lost or duplicated.
- Window marking, `ROWS_PER_WINDOW`=6, 12 rows → `window_last_out` high only on rows 6 and 12.
- Reset mid-group: 3 pairs accepted, then reset, then 6 new pairs → a single row built only from the 6 new pairs.
